uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

UART receive controller for the CPU's serial port: recovers 8N1 frames (optional even parity) from the asynchronous `uart_rx` pin and buffers received bytes in a small first-word-fall-through FIFO. It presents a pop-style read interface and a level interrupt to the CPU peripheral bus. It is the receiving counterpart of the existing UART transmit path.

## Interface
- `CLK_DIV`, 868: clock cycles per bit, e.g. 100 MHz / 115200; must be ≥ 8.
- `FIFO_DEPTH`, 4: receive FIFO entries, a power of two ≥ 2.
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `uart_rx`  in  1  asynchronous serial input; idle high
- `rd_en`  in  1  pop FIFO head; ignored when `rx_valid`=0
- `rd_data`  out  8  FIFO head byte; valid while `rx_valid`=1
- `rx_valid`  out  1  FIFO not empty
- `err_clr`  in  1  clear all sticky error flags
- `frame_err`  out  1  sticky: stop bit sampled low
- `overrun`  out  1  sticky: byte completed while FIFO full
- `par_err`  out  1  sticky: parity mismatch; constant 0 without parity
- `int_rx`  out  1  level interrupt = `rx_valid | frame_err | overrun | par_err`

## Operation
- Reset values:
  - All outputs 0; `rd_data` is 0.
  - FIFO empty; FSM in IDLE.
  - Both synchronizer flops are 1, so no false start is seen after reset.
- Input path: 2-flop synchronizer, then a registered previous-value flop. A start is a 1→0 edge on the synchronized line while in IDLE.
- FSM states:
  - IDLE: on start edge, load bit counter with `CLK_DIV/2 - 1` and go to START.
  - START: at counter expiry, sample the line. Low → DATA with bit index 0. High → false start, back to IDLE.
  - DATA: sample every `CLK_DIV` cycles into a shift register, LSB first. After bit 7 → PARITY if enabled, else STOP.
  - PARITY: sample the bit. Error if the XOR of the 8 data bits and the parity bit is 1.
  - STOP: sample the bit, then return to IDLE in the same cycle.
- Stop-bit outcomes:
  - Sampled high and no parity error: push the byte into the FIFO.
  - Sampled low: set `frame_err`; the byte is discarded.
  - Parity error: set `par_err`; the byte is discarded.
- Push with FIFO full and no pop in the same cycle: set `overrun`. The new byte is dropped; stored contents are unchanged.
- Push and pop in the same cycle while full: both happen, and no overrun is flagged.
- `err_clr` and a new error event in the same cycle: the set wins.
- The bit counter is `$clog2(CLK_DIV)` bits wide and reloads to `CLK_DIV-1` at each sample.

## Timing
- t0 is the first cycle the synchronized line reads 0. The pin-to-t0 delay is 2 cycles.
- Sample instants:
  - start bit: t0 + `CLK_DIV/2`
  - data bit i: t0 + `CLK_DIV/2` + (i+1)·`CLK_DIV`
  - stop bit: t0 + `CLK_DIV/2` + 9·`CLK_DIV`, or +10·`CLK_DIV` with parity
- FIFO write happens in the cycle after the stop sample. `rx_valid` and `rd_data` update 1 cycle later.
- `rd_en` pop: the next head appears on `rd_data` the following cycle. `rx_valid` falls the cycle after the last pop.
- Error flags and `int_rx` assert 1 cycle after the offending sample.
- `rst` asserted mid-frame: the partial byte is abandoned and every state returns to reset values on the next edge.
- A new start edge is accepted from IDLE as early as the cycle after the stop sample.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state is compiled in; frames are 8E1.
  - `par_err` is live.
- `UART_RX_PARITY_EN` undefined:
  - No PARITY state; frames are 8N1.
  - `par_err` is tied to 0; stop timing uses +9·`CLK_DIV`.

## Structure
- Shared package `uart_pkg` holds:
  - FSM state encoding (IDLE, START, DATA, PARITY, STOP)
  - default `CLK_DIV`
  - data width constant 8
- Sub-module `sync_fifo`, parameterized by width and depth, with first-word fall-through and `full`/`empty` outputs. It is reusable by the UART transmit path.

## Test plan
All scenarios use `CLK_DIV`=16 and `FIFO_DEPTH`=4.
- Send 0x55 (8N1) → `rx_valid`=1 at t0+155; `rd_data`=0x55; `int_rx`=1. After `rd_en`, `rx_valid`=0 one cycle later.
- Drive `uart_rx` low for 4 cycles, then high → FSM returns to IDLE; `rx_valid` stays 0; no flags set.
- Send 0xA3 with stop bit 0 → `frame_err`=1, FIFO empty. Pulse `err_clr` → `frame_err`=0, `int_rx`=0.
- Send 0x01–0x05 with no reads → `overrun`=1. Reads return 0x01, 0x02, 0x03, 0x04, then `rx_valid`=0.
- Assert `rst` during bit 3 of a frame, then send 0x3C → exactly one byte 0x3C received; no flags set.
- With `UART_RX_PARITY_EN`: send 0x07 with parity bit 0 → `par_err`=1, FIFO empty. Send 0x07 with parity bit 1 → `rd_data`=0x07.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding, default bit period and data width.
package uart_pkg;

  localparam int unsigned DEFAULT_CLK_DIV = 868;
  localparam int unsigned DATA_W          = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; dout_o shows the head whenever empty_o is low.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: 8N1 (8E1 when UART_RX_PARITY_EN is defined) into a FWFT receive FIFO.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV    = DEFAULT_CLK_DIV,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rx_valid,
  input  logic              err_clr,
  output logic              frame_err,
  output logic              overrun,
  output logic              par_err,
  output logic              int_rx
);
  localparam int unsigned   CW       = $clog2(CLK_DIV);
  localparam int unsigned   FCW      = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned   BW       = $clog2(DATA_W);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLK_DIV - 1);

  logic              sync1_q, sync2_q, prev_q;
  rx_state_e         state_q;
  logic [CW-1:0]     cnt_q;
  logic [BW-1:0]     bit_idx_q;
  logic [DATA_W-1:0] shift_q;
  logic              push_q;
  logic              frame_err_q, overrun_q;
  logic              rx_valid_q, rx_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              tick, frame_set, overrun_set, push_ok;
  logic              pop, occ_full, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_dout;
  logic [FCW-1:0]    fifo_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= uart_rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign tick      = (cnt_q == '0);
  assign frame_set = (state_q == ST_STOP) && tick && !sync2_q;

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_set, par_err_q;
  assign par_set = (state_q == ST_PARITY) && tick && (^{shift_q, sync2_q});
  assign push_ok = !par_bad_q;
  assign par_err = par_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      par_bad_q <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      if ((state_q == ST_IDLE) && prev_q && !sync2_q) par_bad_q <= 1'b0;
      else if (par_set)                               par_bad_q <= 1'b1;
      par_err_q <= (par_err_q && !err_clr) || par_set;
    end
  end
`else
  assign push_ok = 1'b1;
  assign par_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      push_q    <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (state_q != ST_IDLE) cnt_q <= tick ? CNT_FULL : cnt_q - 1'b1;
      case (state_q)
        ST_IDLE: if (prev_q && !sync2_q) begin
          cnt_q   <= CNT_HALF;
          state_q <= ST_START;
        end
        ST_START: if (tick) begin
          bit_idx_q <= '0;
          state_q   <= sync2_q ? ST_IDLE : ST_DATA;
        end
        ST_DATA: if (tick) begin
          shift_q   <= {sync2_q, shift_q[DATA_W-1:1]};
          bit_idx_q <= bit_idx_q + 1'b1;
`ifdef UART_RX_PARITY_EN
          if (bit_idx_q == BW'(DATA_W - 1)) state_q <= ST_PARITY;
`else
          if (bit_idx_q == BW'(DATA_W - 1)) state_q <= ST_STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: if (tick) state_q <= ST_STOP;
`endif
        ST_STOP: if (tick) begin
          push_q  <= sync2_q && push_ok;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // rd_data/rx_valid form a head register in front of the FIFO; occupancy
  // counts the head plus FIFO entries so total capacity stays FIFO_DEPTH.
  assign pop         = rd_en && rx_valid_q;
  assign occ_full    = rx_valid_q && (fifo_count == FCW'(FIFO_DEPTH - 1));
  assign fifo_pop    = !fifo_empty && (!rx_valid_q || pop);
  assign fifo_push   = push_q && (!occ_full || pop) && !fifo_full;
  assign overrun_set = push_q && occ_full && !pop;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (fifo_push),
    .din_i   (shift_q),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    rx_valid_d = rx_valid_q;
    rd_data_d  = rd_data_q;
    if (fifo_pop) begin
      rx_valid_d = 1'b1;
      rd_data_d  = fifo_dout;
    end else if (pop) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_valid_q  <= rx_valid_d;
      rd_data_q   <= rd_data_d;
      frame_err_q <= (frame_err_q && !err_clr) || frame_set;
      overrun_q   <= (overrun_q && !err_clr) || overrun_set;
    end
  end

  assign rx_valid  = rx_valid_q;
  assign rd_data   = rd_data_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign int_rx    = rx_valid_q | frame_err_q | overrun_q | par_err;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomized bench for uart_rx_ctrl (CLK_DIV=16, FIFO_DEPTH=4) against a queue-based receive model.
module tb_uart_rx_ctrl;
  localparam int CLK_DIV = 16;
  localparam int DEPTH   = 4;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rx = 1'b1;
  logic       rd_en = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] rd_data;
  logic       rx_valid, frame_err, overrun, par_err, int_rx;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  logic [7:0] exp_q[$];
  bit         m_frame, m_ovr, m_par;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .rd_en(rd_en), .rd_data(rd_data),
    .rx_valid(rx_valid), .err_clr(err_clr), .frame_err(frame_err),
    .overrun(overrun), .par_err(par_err), .int_rx(int_rx)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Frame outcome by the protocol rules: stop low -> framing error, bad even
  // parity -> parity error, otherwise store unless four bytes already held.
  task automatic model_frame(input logic [7:0] d, input bit stop_b, input bit par_flip);
    bit bad_par;
    bad_par = (PAR_EN != 0) && par_flip;
    if (!stop_b) m_frame = 1;
    if (bad_par) m_par = 1;
    if (stop_b && !bad_par) begin
      if (exp_q.size() == DEPTH) m_ovr = 1;
      else exp_q.push_back(d);
    end
  endtask

  // Caller is aligned 1 time unit after a rising edge.
  task automatic send_frame(input logic [7:0] d, input bit stop_b, input bit par_flip);
    logic [10:0] bits;
    int nb;
    bits = (PAR_EN != 0) ? {stop_b, (^d) ^ par_flip, d, 1'b0} : {1'b1, stop_b, d, 1'b0};
    nb   = (PAR_EN != 0) ? 11 : 10;
    for (int i = 0; i < nb; i++) begin
      uart_rx = bits[i];
      repeat (CLK_DIV) @(posedge clk);
      #1;
    end
    uart_rx = 1'b1;
  endtask

  task automatic frame(input logic [7:0] d, input bit stop_b, input bit par_flip);
    send_frame(d, stop_b, par_flip);
    model_frame(d, stop_b, par_flip);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    @(negedge clk);
    check_eq({tag, "_valid"}, rx_valid, exp_q.size() != 0);
    check_eq({tag, "_frame"}, frame_err, m_frame);
    check_eq({tag, "_ovr"}, overrun, m_ovr);
    check_eq({tag, "_par"}, par_err, m_par);
    check_eq({tag, "_int"}, int_rx, (exp_q.size() != 0) || m_frame || m_ovr || m_par);
    @(posedge clk);
    #1;
  endtask

  task automatic read_check(input string tag);
    logic [7:0] e;
    @(negedge clk);
    check_eq({tag, "_valid"}, rx_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_eq({tag, "_data"}, rd_data, e);
      rd_en = 1'b1;
    end
    @(posedge clk);
    #1;
    rd_en = 1'b0;
  endtask

  task automatic clear_errors();
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    m_frame = 0; m_ovr = 0; m_par = 0;
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() != 0) read_check(tag);
    check_state({tag, "_empty"});
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_rd_data", rd_data, 8'h00);
    check_state("rst");

    // Latency of the first byte and single pop.
    fork
      send_frame(8'h55, 1'b1, 1'b0);
      begin
        repeat (157 + 16 * PAR_EN) @(negedge clk);
        check_eq("lat_before", rx_valid, 1'b0);
        @(negedge clk);
        check_eq("lat_on_time", rx_valid, 1'b1);
      end
    join
    model_frame(8'h55, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check_state("t55");
    drain("t55_rd");

    // Glitch shorter than half a bit is a false start.
    uart_rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    uart_rx = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check_state("false_start");

    frame(8'hA3, 1'b0, 1'b0);
    check_state("frame_err");
    clear_errors();
    check_state("frame_clr");

    for (int i = 1; i <= 5; i++) frame(8'(i), 1'b1, 1'b0);
    check_state("overrun");
    drain("ovr_rd");
    clear_errors();
    check_state("ovr_clr");

    // Pop in the very cycle a byte is pushed into a full buffer.
    for (int i = 0; i < 4; i++) frame(8'hE0 + 8'(i), 1'b1, 1'b0);
    fork
      send_frame(8'h5A, 1'b1, 1'b0);
      begin
        repeat (155 + 16 * PAR_EN) @(posedge clk);
        #1;
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
      end
    join
    void'(exp_q.pop_front());
    model_frame(8'h5A, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check_state("full_pushpop");
    drain("fpp_rd");

    // Reset in the middle of data bit 3, with a byte still buffered.
    frame(8'h99, 1'b1, 1'b0);
    uart_rx = 1'b0;
    repeat (70) @(posedge clk);
    #1;
    rst = 1'b1;
    uart_rx = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    m_frame = 0; m_ovr = 0; m_par = 0;
    @(negedge clk);
    check_eq("midrst_rd_data", rd_data, 8'h00);
    check_state("midrst");
    repeat (20) @(posedge clk);
    #1;
    frame(8'h3C, 1'b1, 1'b0);
    check_state("after_rst");
    drain("after_rst_rd");

    if (PAR_EN != 0) begin
      frame(8'h07, 1'b1, 1'b1);
      check_state("par_bad");
      clear_errors();
      frame(8'h07, 1'b1, 1'b0);
      check_state("par_good");
      drain("par_rd");
    end

    for (int it = 0; it < 24; it++) begin
      logic [7:0] d;
      bit stop_b, pf;
      d      = 8'($urandom);
      stop_b = ($urandom_range(0, 7) != 0);
      pf     = (PAR_EN != 0) && ($urandom_range(0, 5) == 0);
      frame(d, stop_b, pf);
      if ($urandom_range(0, 2) == 0) begin
        int unsigned nrd;
        nrd = $urandom_range(0, exp_q.size());
        for (int k = 0; k < int'(nrd); k++) read_check("rnd_rd");
        check_state("rnd_state");
        if ($urandom_range(0, 1) == 0) clear_errors();
      end
    end
    check_state("rnd_end");
    drain("rnd_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
